activation_sequencer: RTL and testbench
=======================================

Name: activation_sequencer

Overview:
Activation-stage controller. It decodes activation instructions from the activation instruction FIFO and forwards all other instructions to the store instruction FIFO. For each activation instruction it sequences a burst of vector-unit operations and issues aligned FIFO read/write strobes through parametrised delay lines. Compared with the previous generation, pipeline delays, length width and opcode are parameters. Issue also stalls per element on source-empty and destination-full, with a deterministic drain phase.

Parameters:
COUNT_W, 8, width of length field, taken from instr[COUNT_W+2:3]; legal range 1..18
ACT_OPCODE, 3'b011, value of instr[31:29] that marks an activation instruction
EXEC_RD_DELAY, 1, issue-to-execute-FIFO-read latency in cycles; minimum 1
ACC_RD_DELAY, 6, issue-to-accum-FIFO-read latency in cycles; minimum 1
WR_DELAY, 12, issue-to-write-strobe latency in cycles; must be at least both read delays

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_instr_fifo_empty  in  1  activation instruction FIFO empty
i_instr_data  in  32  activation instruction FIFO head
o_instr_fifo_rd_en  out  1  pop instruction; combinational
i_store_instr_fifo_full  in  1  store instruction FIFO full
o_store_instr_fifo_wr_en  out  1  push pass-through instruction; combinational
o_idle  out  1  high when the state is IDLE
o_vector_unit_op  out  4  latched instr[24:21]
o_set_param  out  1  one-cycle pulse of instr[25]
i_execute_out_fifo_empty  in  1  source FIFO empty
o_execute_out_fifo_rd_en  out  1  delayed issue strobe
i_accum_fifo_empty  in  1  accum FIFO empty
i_accum_fifo_pfull  in  1  accum FIFO free space ≤ WR_DELAY
o_accum_fifo_rd_en  out  1  delayed issue AND accumulate-read mode
o_accum_fifo_wr_en  out  1  delayed issue AND non-final mode
i_out_fifo_pfull  in  1  output FIFO free space ≤ WR_DELAY
o_out_fifo_wr_en  out  1  delayed issue AND final mode

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers and delay-line stages are 0 and the state is IDLE. All outputs are 0 except o_idle, which is 1.
- State encoding: one-hot, IDLE=001, BUSY=010, DRAIN=100.
- IDLE with !i_instr_fifo_empty and instr[31:29]==ACT_OPCODE:
  - o_instr_fifo_rd_en=1 in the same cycle.
  - Registers latch: op=instr[24:21], final=instr[27], accrd=instr[22], cnt=instr[COUNT_W+2:3].
  - o_set_param=instr[25] in the next cycle only.
  - Next state is BUSY.
- IDLE with any other opcode:
  - If !i_store_instr_fifo_full, o_instr_fifo_rd_en=1 and o_store_instr_fifo_wr_en=1 in the same cycle.
  - Otherwise both stay 0 and the instruction waits.
- IDLE with i_instr_fifo_empty: no action.
- BUSY advance condition: adv = !i_execute_out_fifo_empty AND !(accrd AND i_accum_fifo_empty) AND !(final ? i_out_fifo_pfull : i_accum_fifo_pfull).
- BUSY issue: when adv, issue=1 for that cycle; otherwise the block stalls with no issue.
- BUSY element count:
  - Each issue with cnt!=0 decrements cnt.
  - An issue with cnt==0 is the last one; next state is DRAIN.
  - A burst therefore issues exactly len+1 elements. len=0 gives a single element.
- DRAIN: a timer loads WR_DELAY on entry and decrements once per cycle; at 0 the next state is IDLE.
  - No strobe may be in any delay line when IDLE is re-entered.
  - The first instruction pop may occur in the first IDLE cycle.
- Delay lines: the issue strobe (qualified per output) passes through fixed shift registers of EXEC_RD_DELAY, ACC_RD_DELAY and WR_DELAY stages.
  - Strobes keep their issue-cycle spacing, including stall gaps.
- o_vector_unit_op holds its value until the next activation instruction is accepted.
- Empty flags are sampled at issue time. This block is the sole consumer of both source FIFOs.
- Programmable-full flags must be sized by the system for WR_DELAY writes in flight.
- Asynchronous reset mid-burst discards all in-flight strobes; no partial pulse is emitted after reset release.

Optional Feature:
ACT_PERF_CNT_EN:
- When defined, adds ports i_perf_clr (in, 1), o_busy_cycles (out, 32) and o_stall_cycles (out, 32).
- The counters saturate and increment per cycle: busy in BUSY or DRAIN, stall in BUSY with !adv.
- They are cleared by reset or by i_perf_clr; i_perf_clr has priority over increment.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package act_pkg holds:
  - state localparams (IDLE, BUSY, DRAIN);
  - instruction field bit positions (OPC_MSB/LSB, FINAL_BIT, SETP_BIT, OP_MSB/LSB, ACCRD_BIT, LEN_LSB);
  - ACT_OPCODE default.
- One sub-module, act_seq_delay_line: a parametrised DATA_WIDTH/DELAY shift register with async active-low clear, instantiated three times.

Test Plan:
- Non-activation instr (opcode 3'b000), store FIFO not full -> rd_en and wr_en both 1 for exactly 1 cycle; state stays IDLE.
- Same instr with store FIFO full for 5 cycles -> no pops during the full period, then a single pop.
- Activation instr with len=3, final=0, accrd=1, no stalls:
  - 4 consecutive issues;
  - exec rd_en on cycles +1..+4 after issue start;
  - accum rd_en at +6..+9;
  - accum wr_en at +12..+15;
  - o_idle returns to 1 after the DRAIN of 12 cycles.
- len=0, final=1 -> one o_out_fifo_wr_en pulse 12 cycles after issue; o_accum_fifo_wr_en never asserts.
- len=7 with i_execute_out_fifo_empty high on issue cycles 3-4 -> 8 issues total; gaps of 2 cycles reproduced on every delayed output.
- rst_n low mid-burst at issue 2 of 8 -> all outputs 0 immediately, no strobe after release, state IDLE.

Source files
------------

// File: rtl/act_pkg.sv
// Shared definitions for the activation sequencer: state encoding,
// instruction field positions and the default activation opcode.
package act_pkg;

  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] BUSY  = 3'b010;
  localparam logic [2:0] DRAIN = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_BUSY  = BUSY,
    ST_DRAIN = DRAIN
  } state_t;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 29;
  localparam int FINAL_BIT = 27;
  localparam int SETP_BIT  = 25;
  localparam int OP_MSB    = 24;
  localparam int OP_LSB    = 21;
  localparam int ACCRD_BIT = 22;
  localparam int LEN_LSB   = 3;

  localparam logic [2:0] ACT_OPCODE_DEF = 3'b011;

endpackage

// File: rtl/act_seq_delay_line.sv
// Fixed-latency shift register; q follows d exactly DELAY cycles later.
// The asynchronous clear empties every stage so no stale strobe survives reset.
module act_seq_delay_line #(
  parameter int DATA_WIDTH = 1,
  parameter int DELAY      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stages [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DELAY; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DELAY-1];

endmodule

// File: rtl/activation_sequencer.sv
// Activation-stage controller: pops instructions, forwards non-activation ones
// to the store FIFO and sequences element bursts with delayed FIFO strobes.
// Optional saturating busy/stall counters are built when ACT_PERF_CNT_EN is defined.
module activation_sequencer
  import act_pkg::*;
#(
  parameter int         COUNT_W       = 8,
  parameter logic [2:0] ACT_OPCODE    = ACT_OPCODE_DEF,
  parameter int         EXEC_RD_DELAY = 1,
  parameter int         ACC_RD_DELAY  = 6,
  parameter int         WR_DELAY      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_fifo_empty,
  input  logic [31:0] i_instr_data,
  output logic        o_instr_fifo_rd_en,
  input  logic        i_store_instr_fifo_full,
  output logic        o_store_instr_fifo_wr_en,
  output logic        o_idle,
  output logic [3:0]  o_vector_unit_op,
  output logic        o_set_param,
  input  logic        i_execute_out_fifo_empty,
  output logic        o_execute_out_fifo_rd_en,
  input  logic        i_accum_fifo_empty,
  input  logic        i_accum_fifo_pfull,
  output logic        o_accum_fifo_rd_en,
  output logic        o_accum_fifo_wr_en,
  input  logic        i_out_fifo_pfull,
`ifdef ACT_PERF_CNT_EN
  input  logic        i_perf_clr,
  output logic [31:0] o_busy_cycles,
  output logic [31:0] o_stall_cycles,
`endif
  output logic        o_out_fifo_wr_en
);

  localparam int TMR_W = $clog2(WR_DELAY + 1);

  state_t             state;
  logic [COUNT_W-1:0] cnt;
  logic [TMR_W-1:0]   timer;
  logic               final_q;
  logic               accrd_q;
  logic               is_act;
  logic               accept;
  logic               pass;
  logic               adv;
  logic               issue;
  logic               unused_instr;

  assign unused_instr = ^i_instr_data;

  assign is_act = (i_instr_data[OPC_MSB:OPC_LSB] == ACT_OPCODE);
  assign accept = (state == ST_IDLE) && !i_instr_fifo_empty && is_act;
  assign pass   = (state == ST_IDLE) && !i_instr_fifo_empty && !is_act && !i_store_instr_fifo_full;

  assign o_instr_fifo_rd_en       = accept || pass;
  assign o_store_instr_fifo_wr_en = pass;
  assign o_idle                   = (state == ST_IDLE);

  // The destination check follows the burst mode: final bursts write the
  // output FIFO, intermediate bursts write back into the accumulator FIFO.
  assign adv = !i_execute_out_fifo_empty
            && !(accrd_q && i_accum_fifo_empty)
            && !(final_q ? i_out_fifo_pfull : i_accum_fifo_pfull);
  assign issue = (state == ST_BUSY) && adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      timer            <= '0;
      final_q          <= 1'b0;
      accrd_q          <= 1'b0;
      o_vector_unit_op <= 4'd0;
      o_set_param      <= 1'b0;
    end else begin
      o_set_param <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_vector_unit_op <= i_instr_data[OP_MSB:OP_LSB];
            final_q          <= i_instr_data[FINAL_BIT];
            accrd_q          <= i_instr_data[ACCRD_BIT];
            cnt              <= i_instr_data[COUNT_W+LEN_LSB-1:LEN_LSB];
            o_set_param      <= i_instr_data[SETP_BIT];
            state            <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (issue) begin
            if (cnt == '0) begin
              state <= ST_DRAIN;
              timer <= TMR_W'(WR_DELAY);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Leave as the timer reaches 0: the last write strobe has then just
          // left the longest delay line, so IDLE starts with all lines empty.
          if (timer <= TMR_W'(1)) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  act_seq_delay_line #(.DATA_WIDTH(1), .DELAY(EXEC_RD_DELAY)) u_exec_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (issue),
    .q     (o_execute_out_fifo_rd_en)
  );

  act_seq_delay_line #(.DATA_WIDTH(1), .DELAY(ACC_RD_DELAY)) u_acc_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (issue && accrd_q),
    .q     (o_accum_fifo_rd_en)
  );

  act_seq_delay_line #(.DATA_WIDTH(2), .DELAY(WR_DELAY)) u_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({issue && final_q, issue && !final_q}),
    .q     ({o_out_fifo_wr_en, o_accum_fifo_wr_en})
  );

`ifdef ACT_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy_cycles  <= '0;
      o_stall_cycles <= '0;
    end else if (i_perf_clr) begin
      o_busy_cycles  <= '0;
      o_stall_cycles <= '0;
    end else begin
      if ((state != ST_IDLE) && (o_busy_cycles != '1))
        o_busy_cycles <= o_busy_cycles + 1'b1;
      if ((state == ST_BUSY) && !adv && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_activation_sequencer.sv
// Directed bench for activation_sequencer: per-cycle output capture into bit
// masks compared against hand-derived timelines (cycle 0 = instruction offered).
module tb_activation_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_instr_fifo_empty;
  logic [31:0] i_instr_data;
  logic        o_instr_fifo_rd_en;
  logic        i_store_instr_fifo_full;
  logic        o_store_instr_fifo_wr_en;
  logic        o_idle;
  logic [3:0]  o_vector_unit_op;
  logic        o_set_param;
  logic        i_execute_out_fifo_empty;
  logic        o_execute_out_fifo_rd_en;
  logic        i_accum_fifo_empty;
  logic        i_accum_fifo_pfull;
  logic        o_accum_fifo_rd_en;
  logic        o_accum_fifo_wr_en;
  logic        i_out_fifo_pfull;
  logic        o_out_fifo_wr_en;
`ifdef ACT_PERF_CNT_EN
  logic        i_perf_clr;
  logic [31:0] o_busy_cycles;
  logic [31:0] o_stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] cap_rd, cap_swr, cap_idle, cap_setp, cap_exec, cap_accrd, cap_accwr, cap_outwr;
  logic        seen;

  activation_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .i_instr_fifo_empty       (i_instr_fifo_empty),
    .i_instr_data             (i_instr_data),
    .o_instr_fifo_rd_en       (o_instr_fifo_rd_en),
    .i_store_instr_fifo_full  (i_store_instr_fifo_full),
    .o_store_instr_fifo_wr_en (o_store_instr_fifo_wr_en),
    .o_idle                   (o_idle),
    .o_vector_unit_op         (o_vector_unit_op),
    .o_set_param              (o_set_param),
    .i_execute_out_fifo_empty (i_execute_out_fifo_empty),
    .o_execute_out_fifo_rd_en (o_execute_out_fifo_rd_en),
    .i_accum_fifo_empty       (i_accum_fifo_empty),
    .i_accum_fifo_pfull       (i_accum_fifo_pfull),
    .o_accum_fifo_rd_en       (o_accum_fifo_rd_en),
    .o_accum_fifo_wr_en       (o_accum_fifo_wr_en),
    .i_out_fifo_pfull         (i_out_fifo_pfull),
`ifdef ACT_PERF_CNT_EN
    .i_perf_clr               (i_perf_clr),
    .o_busy_cycles            (o_busy_cycles),
    .o_stall_cycles           (o_stall_cycles),
`endif
    .o_out_fifo_wr_en         (o_out_fifo_wr_en)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one scenario for n cycles; each mask bit c sets that input in cycle c.
  task automatic run(input logic [31:0] instr, input int n, input logic [63:0] avail,
                     input logic [63:0] sfull, input logic [63:0] x_e, input logic [63:0] a_e,
                     input logic [63:0] a_pf, input logic [63:0] o_pf);
    cap_rd = '0; cap_swr = '0; cap_idle = '0; cap_setp = '0;
    cap_exec = '0; cap_accrd = '0; cap_accwr = '0; cap_outwr = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      i_instr_data             = instr;
      i_instr_fifo_empty       = !avail[c];
      i_store_instr_fifo_full  = sfull[c];
      i_execute_out_fifo_empty = x_e[c];
      i_accum_fifo_empty       = a_e[c];
      i_accum_fifo_pfull       = a_pf[c];
      i_out_fifo_pfull         = o_pf[c];
      @(negedge clk);
      cap_rd[c]    = o_instr_fifo_rd_en;
      cap_swr[c]   = o_store_instr_fifo_wr_en;
      cap_idle[c]  = o_idle;
      cap_setp[c]  = o_set_param;
      cap_exec[c]  = o_execute_out_fifo_rd_en;
      cap_accrd[c] = o_accum_fifo_rd_en;
      cap_accwr[c] = o_accum_fifo_wr_en;
      cap_outwr[c] = o_out_fifo_wr_en;
    end
    i_instr_fifo_empty       = 1'b1;
    i_store_instr_fifo_full  = 1'b0;
    i_execute_out_fifo_empty = 1'b0;
    i_accum_fifo_empty       = 1'b0;
    i_accum_fifo_pfull       = 1'b0;
    i_out_fifo_pfull         = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_instr_fifo_empty = 1'b1;
    i_instr_data = 32'd0;
    i_store_instr_fifo_full = 1'b0;
    i_execute_out_fifo_empty = 1'b0;
    i_accum_fifo_empty = 1'b0;
    i_accum_fifo_pfull = 1'b0;
    i_out_fifo_pfull = 1'b0;
`ifdef ACT_PERF_CNT_EN
    i_perf_clr = 1'b0;
`endif

    // Reset state: only o_idle high
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({o_instr_fifo_rd_en, o_store_instr_fifo_wr_en, o_idle, o_set_param,
             o_execute_out_fifo_rd_en, o_accum_fifo_rd_en, o_accum_fifo_wr_en,
             o_out_fifo_wr_en, o_vector_unit_op}),
        64'h200);
    rst_n = 1'b1;

    // Pass-through, store FIFO ready: single pop+push in cycle 0
    run(32'h0000_1234, 4, m(0, 0), 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("pass_rd", cap_rd, m(0, 0));
    chk("pass_wr", cap_swr, m(0, 0));
    chk("pass_idle", cap_idle, m(0, 3));

    // Pass-through held off by store full for 5 cycles, pops in cycle 5
    run(32'h0000_1234, 8, m(0, 5), m(0, 4), 64'd0, 64'd0, 64'd0, 64'd0);
    chk("wait_rd", cap_rd, m(5, 5));
    chk("wait_wr", cap_swr, m(5, 5));
    chk("wait_idle", cap_idle, m(0, 7));

    // len=3 final=0 accrd=1 set_param=1 op=2: issues 1..4, drain 5..16
    run(32'h6240_0018, 24, m(0, 0), 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("b4_rd", cap_rd, m(0, 0));
    chk("b4_swr", cap_swr, 64'd0);
    chk("b4_setp", cap_setp, m(1, 1));
    chk("b4_exec", cap_exec, m(2, 5));
    chk("b4_accrd", cap_accrd, m(7, 10));
    chk("b4_accwr", cap_accwr, m(13, 16));
    chk("b4_outwr", cap_outwr, 64'd0);
    chk("b4_idle", cap_idle, m(0, 23) & ~m(1, 16));
    chk("b4_op", 64'(o_vector_unit_op), 64'h2);

    // len=0 final=1 accrd=0 op=5: one issue at cycle 1, out write at 13
    run(32'h68A0_0000, 18, m(0, 0), 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    chk("b1_exec", cap_exec, m(2, 2));
    chk("b1_accrd", cap_accrd, 64'd0);
    chk("b1_accwr", cap_accwr, 64'd0);
    chk("b1_outwr", cap_outwr, m(13, 13));
    chk("b1_setp", cap_setp, 64'd0);
    chk("b1_idle", cap_idle, m(0, 17) & ~m(1, 13));
    chk("b1_op", 64'(o_vector_unit_op), 64'h5);

    // len=7 with exec empty in cycles 3-4: issues 1,2,5..10
    run(32'h6040_0038, 30, m(0, 0), 64'd0, m(3, 4), 64'd0, 64'd0, 64'd0);
    chk("b8_exec", cap_exec, m(2, 3) | m(6, 11));
    chk("b8_accrd", cap_accrd, m(7, 8) | m(11, 16));
    chk("b8_accwr", cap_accwr, m(13, 14) | m(17, 22));
    chk("b8_outwr", cap_outwr, 64'd0);
    chk("b8_idle", cap_idle, m(0, 29) & ~m(1, 22));

    // len=1 final=1 accrd=1: out pfull stalls cycle 1, accum empty stalls
    // cycle 3, accum pfull ignored in final mode -> issues at 2 and 4
    run(32'h6840_0008, 20, m(0, 0), 64'd0, 64'd0, m(3, 3), m(0, 19), m(1, 1));
    chk("st_exec", cap_exec, m(3, 3) | m(5, 5));
    chk("st_accrd", cap_accrd, m(8, 8) | m(10, 10));
    chk("st_outwr", cap_outwr, m(14, 14) | m(16, 16));
    chk("st_accwr", cap_accwr, 64'd0);
    chk("st_idle", cap_idle, m(0, 19) & ~m(1, 16));

    // Reset asserted during issue 2 of an 8-element burst
    @(posedge clk); #1;
    i_instr_data = 32'h6040_0038;
    i_instr_fifo_empty = 1'b0;
    @(posedge clk); #1;
    i_instr_fifo_empty = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        64'({o_instr_fifo_rd_en, o_store_instr_fifo_wr_en, o_idle, o_set_param,
             o_execute_out_fifo_rd_en, o_accum_fifo_rd_en, o_accum_fifo_wr_en,
             o_out_fifo_wr_en, o_vector_unit_op}),
        64'h200);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    cap_idle = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | o_execute_out_fifo_rd_en | o_accum_fifo_rd_en
                  | o_accum_fifo_wr_en | o_out_fifo_wr_en | o_set_param;
      cap_idle[c] = o_idle;
    end
    chk("rst_no_strobes", 64'(seen), 64'd0);
    chk("rst_idle", cap_idle, m(0, 19));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
